sprite_palette_bank: RTL

SPRITE_PALETTE_BANK -- requirements
Module: sprite_palette_bank

---
 rtl/sprite_palette_bank.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/sprite_palette_bank.sv
// sprite_palette_bank: multi-palette colour lookup with a
// two-stage read pipeline and a frame-timed flash override.
module sprite_palette_bank #(
   parameter int                 N_PAL        = 4,
   parameter int                 IDX_W        = 4,
   parameter int                 CH_W         = 4,
   parameter int                 TRANSP_IDX   = 0,
   parameter int                 FLASH_FRAMES = 8,
   parameter logic [3*CH_W-1:0]  FLASH_COLOR  = 12'hFFF,
   localparam int                PW = (N_PAL > 1) ? $clog2(N_PAL) : 1
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic                pix_valid_in,
   input  logic [PW-1:0]       pal_sel,
   input  logic [IDX_W-1:0]    index,
   output logic [CH_W-1:0]     red,
   output logic [CH_W-1:0]     green,
   output logic [CH_W-1:0]     blue,
   output logic                transparent,
   output logic                pix_valid_out,
   input  logic                wr_en,
   input  logic [PW-1:0]       wr_pal,
   input  logic [IDX_W-1:0]    wr_idx,
   input  logic [3*CH_W-1:0]   wr_data,
   output logic                wr_err,
   input  logic                frame_tick,
   input  logic                flash_start,
   output logic                flash_busy
);

   localparam int NE  = 2 ** IDX_W;
   localparam int DW  = 3 * CH_W;
   localparam int CNW = (FLASH_FRAMES > 0) ?
                        $clog2(FLASH_FRAMES + 1) : 1;

   localparam logic [CNW-1:0]   FF_LD = CNW'(FLASH_FRAMES);
   localparam logic [PW:0]      NP    = (PW + 1)'(N_PAL);
   localparam logic [IDX_W-1:0] TIDX  = IDX_W'(TRANSP_IDX);

   typedef enum logic {
      IDLE  = 1'b0,
      FLASH = 1'b1
   } st_t;

   // Widen a 4-bit reference channel value into CH_W bits,
   // low-aligned and zero-extended.
   function automatic logic [CH_W-1:0] ch_ext(
      input logic [3:0] nib
   );
      logic [CH_W+3:0] t;
      t = {{CH_W{1'b0}}, nib};
      return t[CH_W-1:0];
   endfunction

   // Power-on palette contents, identical for every palette.
   function automatic logic [DW-1:0] dflt(input int e);
      logic [11:0] v;
      case (e)
         0:       v = 12'hAEA;
         1:       v = 12'hA01;
         2:       v = 12'hFFF;
         3:       v = 12'h000;
         4:       v = 12'hF76;
         5:       v = 12'h050;
         default: v = 12'hAEA;
      endcase
      return {ch_ext(v[11:8]), ch_ext(v[7:4]),
              ch_ext(v[3:0])};
   endfunction

   logic [DW-1:0]  mem_q [N_PAL][NE];
   logic           wr_ok;
   logic           rd_ok;
   logic [DW-1:0]  rd_data;

   logic           v1_q;
   logic [DW-1:0]  d1_q;
   logic           t1_q;

   logic           v2_q;
   logic [DW-1:0]  rgb_q;
   logic [DW-1:0]  rgb_d;
   logic           tr_q;
   logic           tr_d;

   logic           err_q;

   st_t            state_q;
   st_t            state_d;
   logic [CNW-1:0] cnt_q;
   logic [CNW-1:0] cnt_d;
   logic           phase_q;
   logic           phase_d;

   assign wr_ok = wr_en && ({1'b0, wr_pal} < NP);
   assign rd_ok = {1'b0, pal_sel} < NP;

   // Palette read port; out-of-range palettes read as zero.
   always_comb begin
      rd_data = '0;
      if (rd_ok) begin
         rd_data = mem_q[pal_sel][index];
      end
   end

   // Palette storage: reset to the default table, one write per cycle.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int p = 0; p < N_PAL; p++) begin
            for (int e = 0; e < NE; e++) begin
               mem_q[p][e] <= dflt(e);
            end
         end
      end else if (wr_ok) begin
         mem_q[wr_pal][wr_idx] <= wr_data;
      end
   end

   // Stage 1: capture the pre-write entry and the transparency flag.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         v1_q <= 1'b0;
         d1_q <= '0;
         t1_q <= 1'b0;
      end else begin
         v1_q <= pix_valid_in;
         d1_q <= pix_valid_in ? rd_data : '0;
         t1_q <= pix_valid_in && (index == TIDX);
      end
   end

   // Stage 2 next values: flash override applies to opaque pixels only.
   always_comb begin
      rgb_d = '0;
      tr_d  = 1'b0;
      if (v1_q) begin
         tr_d  = t1_q;
         rgb_d = (phase_q && !t1_q) ? FLASH_COLOR : d1_q;
      end
   end

   // Stage 2: output registers, zero whenever not valid.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         v2_q  <= 1'b0;
         rgb_q <= '0;
         tr_q  <= 1'b0;
      end else begin
         v2_q  <= v1_q;
         rgb_q <= rgb_d;
         tr_q  <= tr_d;
      end
   end

   // Rejected write strobe, reported on the following cycle.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= wr_en && !wr_ok;
      end
   end

   // Flash sequencer next state: start/restart beats a frame tick.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      unique case (state_q)
         IDLE: begin
            if (flash_start && (FLASH_FRAMES > 0)) begin
               state_d = FLASH;
               cnt_d   = FF_LD;
               phase_d = 1'b1;
            end
         end
         FLASH: begin
            if (flash_start) begin
               cnt_d   = FF_LD;
               phase_d = 1'b1;
            end else if (frame_tick) begin
               if (cnt_q <= CNW'(1)) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  phase_d = 1'b0;
               end else begin
                  cnt_d   = cnt_q - CNW'(1);
                  phase_d = !phase_q;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            phase_d = 1'b0;
         end
      endcase
   end

   // Flash sequencer state register.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign red           = rgb_q[DW-1:2*CH_W];
   assign green         = rgb_q[2*CH_W-1:CH_W];
   assign blue          = rgb_q[CH_W-1:0];
   assign transparent   = tr_q;
   assign pix_valid_out = v2_q;
   assign wr_err        = err_q;
   assign flash_busy    = (state_q == FLASH);

endmodule
